bus_io_timer: RTL and testbench
===============================

Name: bus_io_timer

Overview:
- Memory-mapped timer/compare peripheral on the sigma req/ack/resp slave bus.
- Sits directly downstream of the bus unit's IO decode (address bit 31 set) as a dedicated IO slave.
- Provides a prescaled 32-bit up-counter, a compare match with a sticky flag, optional auto-reload, and a level interrupt output.

Parameters:
PRESC_WIDTH, 16, width of the PRESCALE register and the internal prescaler counter
BASE_OFFSET, 8'h10, value of addr_bi[7:0] at which the register window starts

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  asynchronous, active-low reset (asserted when 0)
req_i  in  1  bus request
we_i  in  1  1 = write, 0 = read
addr_bi  in  32  byte address; only [7:0] decoded
be_bi  in  4  byte enables for writes
wdata_bi  in  32  write data
ack_o  out  1  request accepted this cycle
resp_o  out  1  read data valid
rdata_bo  out  32  read data
irq_o  out  1  level interrupt

Behaviour:
- Register map, offset = addr_bi[7:0] - BASE_OFFSET:
  - 0x00 CTRL: [0] EN, [1] AUTORELOAD, [2] IRQEN; other bits read 0.
  - 0x04 PRESCALE: [PRESC_WIDTH-1:0]; upper bits read 0.
  - 0x08 COUNT
  - 0x0C COMPARE
  - 0x10 STATUS: [0] MATCH; write-1-to-clear.
- Other offsets: reads return 32'h55aa55aa; writes are ignored.
- Reset (rst_i=0, asynchronous): ack_o=0, resp_o=0, rdata_bo=0, irq_o=0. All registers and the prescaler counter go to 0. Any pending read response is dropped.
- Handshake:
  - ack_o = req_i combinationally; the block never stalls.
  - A request is accepted in any cycle with req_i & ack_o.
  - Accepted read: rdata is captured at that clock edge from register values before that edge's updates. resp_o=1 for exactly the next cycle with rdata_bo valid.
  - Back-to-back reads give back-to-back resp pulses, one per read, in order.
  - Accepted write: never produces resp_o.
  - rdata_bo holds its last value when resp_o=0.
- Writes: per-byte update using be_bi; be_bi=0 writes nothing.
  - Writing PRESCALE (any byte) also clears the prescaler counter.
- Counting, each cycle with EN=1:
  - If pcnt == PRESCALE: pcnt <= 0 and a tick occurs; otherwise pcnt <= pcnt+1.
  - PRESCALE=0 gives a tick every enabled cycle.
  - EN=0: pcnt and COUNT hold; they are not cleared.
- On a tick:
  - If COUNT == COMPARE: MATCH <= 1, and COUNT <= (AUTORELOAD ? 0 : COUNT+1).
  - Otherwise COUNT <= COUNT+1.
  - Arithmetic is modulo 2^32; 32'hFFFFFFFF wraps to 0 without setting MATCH unless COMPARE equals 32'hFFFFFFFF.
- Simultaneous events:
  - Software write to COUNT in a tick cycle: the write wins for the written bytes; unwritten bytes take the tick result.
  - MATCH set and W1C clear in the same cycle: set wins.
  - Read of COUNT in a tick cycle returns the pre-tick value.
- irq_o = MATCH & IRQEN, driven combinationally from registers.
- Reset mid-read: resp_o falls immediately, asynchronously; no resp is produced after reset release.

Test Plan:
1. Reset, then read each register offset 0x00–0x10 plus offset 0x14 -> ack_o=1 on each request cycle. Each resp_o arrives exactly one cycle later. Data: 0,0,0,0,0, then 32'h55aa55aa.
2. Write PRESCALE=3, COMPARE=5, CTRL=32'h7 -> COUNT increments every 4 cycles. MATCH and irq_o rise on the tick where COUNT was 5; COUNT becomes 0 on that tick. Writing STATUS=1 drops irq_o the next cycle.
3. AUTORELOAD=0, PRESCALE=0, COUNT=32'hFFFFFFFE, COMPARE=32'h10 -> COUNT reads FFFFFFFF, then 0, then 1; MATCH stays 0.
4. Write COUNT=32'h12345678 with be_bi=4'b0011 in a tick cycle, prior COUNT=32'hAAAA0000 -> COUNT=32'hAAAA5678.
5. Two back-to-back reads (COMPARE, then CTRL) -> two consecutive resp_o pulses carrying the COMPARE then CTRL values. A write inserted between them produces no resp_o.
6. Issue a read, then assert rst_i=0 in the following cycle before the clock edge -> resp_o goes 0 immediately. All registers read 0 after release.

Source files
------------

// File: rtl/bus_io_timer.sv
// bus_io_timer
//   Memory-mapped timer/compare peripheral on the req/ack/resp IO slave bus.
//   A prescaler divides the clock into ticks, and each tick advances a 32-bit
//   up-counter. When the counter equals COMPARE on a tick, a sticky MATCH flag
//   is set. The counter can optionally auto-reload to zero at that point. A
//   level interrupt is raised while MATCH and IRQEN are both set.
//
//   Register window (offset = addr_bi[7:0] - BASE_OFFSET):
//     0x00 CTRL     [0] EN, [1] AUTORELOAD, [2] IRQEN
//     0x04 PRESCALE [PRESC_WIDTH-1:0]
//     0x08 COUNT
//     0x0C COMPARE
//     0x10 STATUS   [0] MATCH (write 1 to clear)
//   Any other offset reads 32'h55aa55aa and ignores writes.
//
// Ports:
//   clk_i     clock, all state updates on the rising edge
//   rst_i     asynchronous active-low reset
//   req_i     bus request
//   we_i      1 = write, 0 = read
//   addr_bi   byte address, only [7:0] decoded
//   be_bi     write byte enables
//   wdata_bi  write data
//   ack_o     request accepted (mirrors req_i, never stalls)
//   resp_o    read data valid, one cycle after an accepted read
//   rdata_bo  read data, holds its value while resp_o is low
//   irq_o     level interrupt (MATCH & IRQEN)
module bus_io_timer #(
  parameter int          PRESC_WIDTH = 16,
  parameter logic [7:0]  BASE_OFFSET = 8'h10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_bi,
  input  logic [3:0]  be_bi,
  input  logic [31:0] wdata_bi,
  output logic        ack_o,
  output logic        resp_o,
  output logic [31:0] rdata_bo,
  output logic        irq_o
);

  localparam logic [7:0]  OFF_CTRL     = 8'h00;
  localparam logic [7:0]  OFF_PRESCALE = 8'h04;
  localparam logic [7:0]  OFF_COUNT    = 8'h08;
  localparam logic [7:0]  OFF_COMPARE  = 8'h0C;
  localparam logic [7:0]  OFF_STATUS   = 8'h10;
  localparam logic [31:0] UNMAPPED_VAL = 32'h55aa55aa;

  // Register state
  logic                   en;
  logic                   autoreload;
  logic                   irqen;
  logic [PRESC_WIDTH-1:0] prescale;
  logic [PRESC_WIDTH-1:0] pcnt;
  logic [31:0]            count;
  logic [31:0]            compare;
  logic                   match;
  logic                   resp_q;
  logic [31:0]            rdata_q;

  // Decode and next-state helpers
  logic [7:0]  offset;
  logic        rd_acc;
  logic        wr_acc;
  logic        wr_ctrl;
  logic        wr_presc;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        tick;
  logic        count_hit;
  logic        match_set;
  logic [31:0] count_tick;
  logic [31:0] presc_ext;
  logic [31:0] presc_merged;
  logic [31:0] rd_mux;
  logic        unused_bits;

  // Replace only the enabled bytes of old_val with new_val.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  assign ack_o    = req_i;
  assign resp_o   = resp_q;
  assign rdata_bo = rdata_q;
  assign irq_o    = match & irqen;

  assign offset = addr_bi[7:0] - BASE_OFFSET;
  assign rd_acc = req_i & ~we_i;
  assign wr_acc = req_i & we_i;

  // A write with be_bi == 0 touches nothing, including the prescaler clear.
  assign wr_ctrl    = wr_acc && (offset == OFF_CTRL) && be_bi[0];
  assign wr_presc   = wr_acc && (offset == OFF_PRESCALE) && (be_bi != 4'b0000);
  assign wr_count   = wr_acc && (offset == OFF_COUNT) && (be_bi != 4'b0000);
  assign wr_compare = wr_acc && (offset == OFF_COMPARE) && (be_bi != 4'b0000);
  assign wr_status  = wr_acc && (offset == OFF_STATUS) && be_bi[0] && wdata_bi[0];

  assign unused_bits = ^{addr_bi[31:8], presc_merged};

  // Zero-extended view of PRESCALE and its byte-merged write value.
  always_comb begin
    presc_ext = '0;
    presc_ext[PRESC_WIDTH-1:0] = prescale;
    presc_merged = merge_bytes(presc_ext, wdata_bi, be_bi);
  end

  // Tick and counter update before any software write is layered on top.
  always_comb begin
    tick       = en && (pcnt == prescale);
    count_hit  = (count == compare);
    match_set  = tick && count_hit;
    count_tick = count;
    if (tick) begin
      if (count_hit && autoreload) count_tick = '0;
      else                         count_tick = count + 32'd1;
    end
  end

  // Read multiplexer, sampled at the accepting edge from pre-edge values.
  always_comb begin
    rd_mux = UNMAPPED_VAL;
    case (offset)
      OFF_CTRL:     rd_mux = {29'd0, irqen, autoreload, en};
      OFF_PRESCALE: rd_mux = presc_ext;
      OFF_COUNT:    rd_mux = count;
      OFF_COMPARE:  rd_mux = compare;
      OFF_STATUS:   rd_mux = {31'd0, match};
      default:      rd_mux = UNMAPPED_VAL;
    endcase
  end

  // Register updates. A COUNT write overrides only the written bytes of the
  // tick result, and a MATCH set beats a same-cycle write-1-to-clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      en         <= 1'b0;
      autoreload <= 1'b0;
      irqen      <= 1'b0;
      prescale   <= '0;
      pcnt       <= '0;
      count      <= '0;
      compare    <= '0;
      match      <= 1'b0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        en         <= wdata_bi[0];
        autoreload <= wdata_bi[1];
        irqen      <= wdata_bi[2];
      end

      if (wr_presc) begin
        prescale <= presc_merged[PRESC_WIDTH-1:0];
        pcnt     <= '0;
      end else if (en) begin
        pcnt <= tick ? '0 : pcnt + PRESC_WIDTH'(1);
      end

      count <= wr_count ? merge_bytes(count_tick, wdata_bi, be_bi) : count_tick;

      if (wr_compare) compare <= merge_bytes(compare, wdata_bi, be_bi);

      if (match_set)      match <= 1'b1;
      else if (wr_status) match <= 1'b0;

      resp_q <= rd_acc;
      if (rd_acc) rdata_q <= rd_mux;
    end
  end

endmodule

// File: tb/tb_bus_io_timer.sv
// tb_bus_io_timer
//   Self-checking bench for bus_io_timer. A table of bus transactions with
//   hand-computed read values covers reset state and byte-enable writes;
//   hand-written sequences cover counting, wrap, tick/write collisions,
//   back-to-back reads and reset during a pending read.
module tb_bus_io_timer;

  localparam logic [7:0] BASE = 8'h10;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_bi = '0;
  logic [3:0]  be_bi = '0;
  logic [31:0] wdata_bi = '0;
  logic        ack_o;
  logic        resp_o;
  logic [31:0] rdata_bo;
  logic        irq_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        we;
    logic [7:0]  off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  bus_io_timer #(
    .PRESC_WIDTH(16),
    .BASE_OFFSET(BASE)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_bi  (addr_bi),
    .be_bi    (be_bi),
    .wdata_bi (wdata_bi),
    .ack_o    (ack_o),
    .resp_o   (resp_o),
    .rdata_bo (rdata_bo),
    .irq_o    (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One bus transaction: driven at the falling edge, accepted at the next
  // rising edge; returns 1 time unit after that edge with req dropped.
  task automatic applyStimulus(input logic we, input logic [7:0] off,
                               input logic [3:0] be, input logic [31:0] wdata);
    @(negedge clk_i);
    req_i    = 1'b1;
    we_i     = we;
    addr_bi  = 32'h8000_0000 | {24'h0, off + BASE};
    be_bi    = be;
    wdata_bi = wdata;
    #1;
    checkOutput("ack", {31'd0, ack_o}, 32'd1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0;
    we_i  = 1'b0;
    be_bi = 4'b0000;
  endtask

  task automatic doWrite(input logic [7:0] off, input logic [3:0] be,
                         input logic [31:0] wdata);
    applyStimulus(1'b1, off, be, wdata);
  endtask

  task automatic doRead(input logic [7:0] off, input logic [31:0] exp,
                        input string name);
    applyStimulus(1'b0, off, 4'b0000, 32'h0);
    checkOutput({name, "_resp"}, {31'd0, resp_o}, 32'd1);
    checkOutput(name, rdata_bo, exp);
  endtask

  function automatic void addVec(input logic we, input logic [7:0] off,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 input logic [31:0] exp, input string name);
    vec_t v;
    v.we = we; v.off = off; v.be = be; v.wdata = wdata; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  initial begin
    // Table: reset reads, then byte-enable writes with EN kept at 0.
    addVec(0, 8'h00, 4'h0, 32'h0, 32'h0, "rst_ctrl");
    addVec(0, 8'h04, 4'h0, 32'h0, 32'h0, "rst_presc");
    addVec(0, 8'h08, 4'h0, 32'h0, 32'h0, "rst_count");
    addVec(0, 8'h0C, 4'h0, 32'h0, 32'h0, "rst_compare");
    addVec(0, 8'h10, 4'h0, 32'h0, 32'h0, "rst_status");
    addVec(0, 8'h14, 4'h0, 32'h0, 32'h55aa55aa, "unmapped_14");
    addVec(1, 8'h00, 4'hF, 32'hFFFF_FFF8, 32'h0, "");
    addVec(0, 8'h00, 4'h0, 32'h0, 32'h0, "ctrl_hi_bits");
    addVec(1, 8'h00, 4'hF, 32'h0000_0006, 32'h0, "");
    addVec(0, 8'h00, 4'h0, 32'h0, 32'h6, "ctrl_6");
    addVec(1, 8'h00, 4'hF, 32'h0, 32'h0, "");
    addVec(1, 8'h04, 4'hF, 32'hDEAD_BEEF, 32'h0, "");
    addVec(0, 8'h04, 4'h0, 32'h0, 32'h0000_BEEF, "presc_trunc");
    addVec(1, 8'h04, 4'h2, 32'h1234_5678, 32'h0, "");
    addVec(0, 8'h04, 4'h0, 32'h0, 32'h0000_56EF, "presc_be2");
    addVec(1, 8'h0C, 4'hF, 32'h1122_3344, 32'h0, "");
    addVec(0, 8'h0C, 4'h0, 32'h0, 32'h1122_3344, "compare_full");
    addVec(1, 8'h0C, 4'h0, 32'hFFFF_FFFF, 32'h0, "");
    addVec(0, 8'h0C, 4'h0, 32'h0, 32'h1122_3344, "compare_be0");
    addVec(1, 8'h0C, 4'hA, 32'hAABB_CCDD, 32'h0, "");
    addVec(0, 8'h0C, 4'h0, 32'h0, 32'hAA22_CC44, "compare_beA");
    addVec(1, 8'h08, 4'hF, 32'h0BAD_F00D, 32'h0, "");
    addVec(0, 8'h08, 4'h0, 32'h0, 32'h0BAD_F00D, "count_wr");
    addVec(1, 8'h20, 4'hF, 32'h1234_5678, 32'h0, "");
    addVec(0, 8'h20, 4'h0, 32'h0, 32'h55aa55aa, "unmapped_20");
    addVec(0, 8'h01, 4'h0, 32'h0, 32'h55aa55aa, "unaligned_01");

    // Reset state while rst_i is held low.
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_ack", {31'd0, ack_o}, 32'd0);
    checkOutput("rst_resp", {31'd0, resp_o}, 32'd0);
    checkOutput("rst_rdata", rdata_bo, 32'd0);
    checkOutput("rst_irq", {31'd0, irq_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].we) doWrite(vecs[i].off, vecs[i].be, vecs[i].wdata);
      else            doRead(vecs[i].off, vecs[i].exp, vecs[i].name);
    end

    // Prescaled counting with compare match and auto-reload.
    doWrite(8'h08, 4'hF, 32'h0);
    doWrite(8'h04, 4'hF, 32'd3);
    doWrite(8'h0C, 4'hF, 32'd5);
    doWrite(8'h00, 4'hF, 32'h7);
    for (int n = 1; n <= 28; n++) begin
      int m;
      m = n - 1;
      doRead(8'h08, (m < 24) ? 32'(m / 4) : 32'((m - 24) / 4), "count_presc");
      checkOutput("irq_match", {31'd0, irq_o}, (n >= 24) ? 32'd1 : 32'd0);
    end
    doWrite(8'h10, 4'h1, 32'h1);
    checkOutput("irq_w1c", {31'd0, irq_o}, 32'd0);
    doRead(8'h10, 32'h0, "status_cleared");
    doWrite(8'h00, 4'hF, 32'h0);

    // Wrap through 32'hFFFFFFFF without a match.
    doWrite(8'h04, 4'hF, 32'h0);
    doWrite(8'h08, 4'hF, 32'hFFFF_FFFE);
    doWrite(8'h0C, 4'hF, 32'h10);
    doWrite(8'h00, 4'hF, 32'h1);
    doRead(8'h08, 32'hFFFF_FFFE, "wrap_0");
    doRead(8'h08, 32'hFFFF_FFFF, "wrap_1");
    doRead(8'h08, 32'h0000_0000, "wrap_2");
    doRead(8'h08, 32'h0000_0001, "wrap_3");
    doRead(8'h10, 32'h0, "wrap_nomatch");
    doWrite(8'h00, 4'hF, 32'h0);

    // Partial COUNT write colliding with a tick.
    doWrite(8'h08, 4'hF, 32'hAAAA_0000);
    doWrite(8'h00, 4'hF, 32'h1);
    doWrite(8'h08, 4'h3, 32'h1234_5678);
    doRead(8'h08, 32'hAAAA_5678, "count_tick_wr");
    doWrite(8'h00, 4'hF, 32'h0);

    // Back-to-back reads, then reads split by a write.
    doWrite(8'h00, 4'hF, 32'h6);
    doRead(8'h0C, 32'h10, "b2b_compare");
    doRead(8'h00, 32'h6, "b2b_ctrl");
    doRead(8'h0C, 32'h10, "split_compare");
    doWrite(8'h04, 4'hF, 32'h7);
    checkOutput("write_no_resp", {31'd0, resp_o}, 32'd0);
    checkOutput("rdata_hold", rdata_bo, 32'h10);
    doRead(8'h00, 32'h6, "split_ctrl");

    // Reset while a read response is on the bus.
    doRead(8'h0C, 32'h10, "pre_rst_read");
    #2;
    rst_i = 1'b0;
    #1;
    checkOutput("rst_async_resp", {31'd0, resp_o}, 32'd0);
    checkOutput("rst_async_rdata", rdata_bo, 32'd0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("rst_no_resp", {31'd0, resp_o}, 32'd0);
    doRead(8'h00, 32'h0, "post_rst_ctrl");
    doRead(8'h04, 32'h0, "post_rst_presc");
    doRead(8'h08, 32'h0, "post_rst_count");
    doRead(8'h0C, 32'h0, "post_rst_compare");
    doRead(8'h10, 32'h0, "post_rst_status");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
